pll_lock_reset_gen: RTL

PLL_LOCK_RESET_GEN -- requirements
Module: pll_lock_reset_gen

---
 rtl/pll_lock_pkg.sv | 16 +
 rtl/pll_lock_sync.sv | 34 +++
 rtl/pll_lock_reset_gen.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/pll_lock_pkg.sv
// Shared definitions for the PLL lock qualified reset generator.
//   LOSS_CNT_W   : width of the lock-loss event counter output
//   lock_state_e : FSM state encoding
package pll_lock_pkg;

    localparam int LOSS_CNT_W = 8;

    typedef enum logic [2:0] {
        ST_WAIT_LOCK = 3'd0,
        ST_QUALIFY   = 3'd1,
        ST_RELEASE   = 3'd2,
        ST_RUN       = 3'd3,
        ST_LOST      = 3'd4
    } lock_state_e;

endpackage

// File: rtl/pll_lock_sync.sv
// Multi-flop synchronizer bringing the raw PLL lock indication into the
// reference clock domain.
// Ports:
//   clk      : reference clock
//   rst_n    : asynchronous active-low reset, clears every stage to 0
//   async_in : asynchronous input
//   sync_out : synchronized output (last stage of the chain)
module pll_lock_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic async_in,
    output logic sync_out
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES-1:0] sync_d;

    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], async_in};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign sync_out = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/pll_lock_reset_gen.sv
// PLL lock qualified reset generator. Holds the system in reset until the
// synchronized PLL lock has been continuously high for STABLE_CYCLES, then
// waits RELEASE_CYCLES more before releasing SYS_RESET_N. Any lock loss after
// qualification drops SYS_RESET_N and restarts qualification.
// Ports:
//   CLOCK         : free-running reference clock
//   RESET_N       : asynchronous active-low reset
//   PLL_LOCKED    : raw PLL lock, asynchronous to CLOCK
//   SYS_RESET_N   : registered active-low system reset, high only in RUN
//   LOCK_STABLE   : high in RELEASE and RUN
//   LOCK_LOST     : sticky lock-loss flag, cleared only by RESET_N
//   LOCK_LOSS_CNT : saturating lock-loss event count
// Build option: define PLL_LOCK_LOSS_CNT_EN to build the loss counter;
// without it LOCK_LOSS_CNT is tied to 0.
module pll_lock_reset_gen
    import pll_lock_pkg::*;
#(
    parameter int SYNC_STAGES    = 2,
    parameter int STABLE_CYCLES  = 1024,
    parameter int RELEASE_CYCLES = 16
) (
    input  logic                  CLOCK,
    input  logic                  RESET_N,
    input  logic                  PLL_LOCKED,
    output logic                  SYS_RESET_N,
    output logic                  LOCK_STABLE,
    output logic                  LOCK_LOST,
    output logic [LOSS_CNT_W-1:0] LOCK_LOSS_CNT
);

    localparam int CNT_MAX = (STABLE_CYCLES > RELEASE_CYCLES) ? STABLE_CYCLES : RELEASE_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    // Counter starts at 0 on state entry, so the last cycle shows N-1.
    localparam logic [CNT_W-1:0] QUAL_LAST = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] REL_LAST  = CNT_W'(RELEASE_CYCLES - 1);

    lock_state_e      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             lock_s;
    logic             sys_rst_n_q, sys_rst_n_d;
    logic             lock_lost_q, lock_lost_d;
    logic             lock_stable;
    logic             lost_entry;

    pll_lock_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .clk      (CLOCK),
        .rst_n    (RESET_N),
        .async_in (PLL_LOCKED),
        .sync_out (lock_s)
    );

    // State register
    always_ff @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q <= ST_WAIT_LOCK;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next state. Lock loss is tested before terminal count so a drop on the
    // last cycle discards the advance.
    always_comb begin
        state_d = state_q;
        cnt_d   = '0;
        case (state_q)
            ST_WAIT_LOCK: begin
                if (lock_s) state_d = ST_QUALIFY;
            end
            ST_QUALIFY: begin
                if (!lock_s)                 state_d = ST_WAIT_LOCK;
                else if (cnt_q == QUAL_LAST) state_d = ST_RELEASE;
                else                         cnt_d   = cnt_q + CNT_W'(1);
            end
            ST_RELEASE: begin
                if (!lock_s)                state_d = ST_LOST;
                else if (cnt_q == REL_LAST) state_d = ST_RUN;
                else                        cnt_d   = cnt_q + CNT_W'(1);
            end
            ST_RUN: begin
                if (!lock_s) state_d = ST_LOST;
            end
            ST_LOST: begin
                state_d = ST_WAIT_LOCK;
            end
            default: begin
                state_d = ST_WAIT_LOCK;
            end
        endcase
    end

    // Outputs. SYS_RESET_N is registered from the next state so it tracks RUN
    // exactly; LOST lasts one cycle, so state_d == LOST marks a single entry.
    always_comb begin
        lock_stable = (state_q == ST_RELEASE) || (state_q == ST_RUN);
        sys_rst_n_d = (state_d == ST_RUN);
        lost_entry  = (state_d == ST_LOST);
        lock_lost_d = lock_lost_q | lost_entry;
    end

    always_ff @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            sys_rst_n_q <= 1'b0;
            lock_lost_q <= 1'b0;
        end else begin
            sys_rst_n_q <= sys_rst_n_d;
            lock_lost_q <= lock_lost_d;
        end
    end

    assign SYS_RESET_N = sys_rst_n_q;
    assign LOCK_STABLE = lock_stable;
    assign LOCK_LOST   = lock_lost_q;

`ifdef PLL_LOCK_LOSS_CNT_EN
    logic [LOSS_CNT_W-1:0] loss_cnt_q, loss_cnt_d;

    // Saturates at all-ones instead of wrapping.
    always_comb begin
        loss_cnt_d = loss_cnt_q;
        if (lost_entry && (loss_cnt_q != {LOSS_CNT_W{1'b1}})) begin
            loss_cnt_d = loss_cnt_q + LOSS_CNT_W'(1);
        end
    end

    always_ff @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            loss_cnt_q <= '0;
        end else begin
            loss_cnt_q <= loss_cnt_d;
        end
    end

    assign LOCK_LOSS_CNT = loss_cnt_q;
`else
    assign LOCK_LOSS_CNT = '0;
`endif

endmodule
